issueq_free_list: RTL and testbench

//  Recycles issue-queue slots: consumes the encoded entries granted by the select

---
 rtl/issueq_free_list.sv | 127 ++++++++++++
 tb/tb_issueq_free_list.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issueq_free_list.sv
// Issue-queue free list: circular FIFO of slot indices, refilled by the select
// lanes and drained by dispatch DISPATCH_WIDTH slots at a time.
module issueq_free_list #(
  parameter int ISSUE_DEPTH     = 128,
  parameter int ISSUE_DEPTH_LOG = 7,
  parameter int DISPATCH_WIDTH  = 4,
  parameter int GRANT_WIDTH     = 3
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush_i,
  input  logic                                      alloc_i,
  input  logic [GRANT_WIDTH-1:0]                    grantedValid_i,
  input  logic [GRANT_WIDTH*ISSUE_DEPTH_LOG-1:0]    grantedEntry_i,
  output logic [DISPATCH_WIDTH*ISSUE_DEPTH_LOG-1:0] freeEntry_o,
  output logic                                      freeValid_o,
  output logic [ISSUE_DEPTH_LOG:0]                  freeCnt_o,
  output logic                                      error_o
);

  localparam int LOG = ISSUE_DEPTH_LOG;
  localparam int CW  = LOG + 2;

  logic [LOG-1:0] list_q [ISSUE_DEPTH];
  logic [LOG-1:0] list_d [ISSUE_DEPTH];
  logic [LOG-1:0] head_q, head_d;
  logic [LOG-1:0] tail_q, tail_d;
  logic [LOG:0]   count_q, count_d;
  logic           error_q, error_d;

  logic           alloc_ok;
  logic           overflow;
  logic [CW-1:0]  pop;
  logic [CW-1:0]  count_sum;
  logic [LOG-1:0] wr_ptr;
  logic           dup_lanes;

  assign freeValid_o = (count_q >= (LOG+1)'(DISPATCH_WIDTH));
  assign freeCnt_o   = count_q;
  assign error_o     = error_q;

  always_comb begin
    freeEntry_o = '0;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      freeEntry_o[k*LOG +: LOG] = list_q[head_q + LOG'(k)];
    end
  end

  always_comb begin
    list_d    = list_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    error_d   = error_q;
    wr_ptr    = tail_q;
    alloc_ok  = alloc_i && freeValid_o;
    pop       = '0;
    for (int unsigned g = 0; g < GRANT_WIDTH; g++) begin
      pop = pop + CW'(grantedValid_i[g]);
    end
    count_sum = CW'(count_q) + pop - (alloc_ok ? CW'(DISPATCH_WIDTH) : CW'(0));
    overflow  = (count_sum > CW'(ISSUE_DEPTH));

    if (flush_i) begin
      for (int unsigned i = 0; i < ISSUE_DEPTH; i++) begin
        list_d[i] = LOG'(i);
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = (LOG+1)'(ISSUE_DEPTH);
    end else begin
      if (alloc_i && !freeValid_o) begin
        error_d = 1'b1;
      end
      if (alloc_ok) begin
        head_d = head_q + LOG'(DISPATCH_WIDTH);
      end
      if (overflow) begin
        error_d = 1'b1;
        count_d = (LOG+1)'(ISSUE_DEPTH);
      end else begin
        // Running write pointer compacts valid lanes so skipped lanes leave no hole.
        for (int unsigned g = 0; g < GRANT_WIDTH; g++) begin
          if (grantedValid_i[g]) begin
            list_d[wr_ptr] = grantedEntry_i[g*LOG +: LOG];
            wr_ptr         = wr_ptr + 1'b1;
          end
        end
        tail_d  = wr_ptr;
        count_d = (LOG+1)'(count_sum);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ISSUE_DEPTH; i++) begin
        list_q[i] <= LOG'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= (LOG+1)'(ISSUE_DEPTH);
      error_q <= 1'b0;
    end else begin
      list_q  <= list_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    dup_lanes = 1'b0;
    for (int unsigned a = 0; a < GRANT_WIDTH; a++) begin
      for (int unsigned b = a + 1; b < GRANT_WIDTH; b++) begin
        if (grantedValid_i[a] && grantedValid_i[b] &&
            (grantedEntry_i[a*LOG +: LOG] == grantedEntry_i[b*LOG +: LOG])) begin
          dup_lanes = 1'b1;
        end
      end
    end
  end

  no_dup_free_lanes: assert property (@(posedge clk) disable iff (!reset) !dup_lanes);

endmodule

// File: tb/tb_issueq_free_list.sv
// Scoreboard bench for issueq_free_list: freed indices are queued in order and
// compared against freeEntry_o whenever dispatch allocates.
module tb_issueq_free_list;

  localparam int DEPTH = 128;
  localparam int LOG   = 7;
  localparam int DW    = 4;
  localparam int GW    = 3;

  logic              clk            = 1'b0;
  logic              reset          = 1'b0;
  logic              flush_i        = 1'b0;
  logic              alloc_i        = 1'b0;
  logic [GW-1:0]     grantedValid_i = '0;
  logic [GW*LOG-1:0] grantedEntry_i = '0;
  logic [DW*LOG-1:0] freeEntry_o;
  logic              freeValid_o;
  logic [LOG:0]      freeCnt_o;
  logic              error_o;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];
  int out_q[$];
  int exp_cnt  = DEPTH;
  bit exp_err  = 1'b0;

  localparam logic [DW*LOG-1:0] INIT_ENTRIES = {7'd3, 7'd2, 7'd1, 7'd0};

  issueq_free_list #(
    .ISSUE_DEPTH(DEPTH),
    .ISSUE_DEPTH_LOG(LOG),
    .DISPATCH_WIDTH(DW),
    .GRANT_WIDTH(GW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush_i(flush_i),
    .alloc_i(alloc_i),
    .grantedValid_i(grantedValid_i),
    .grantedEntry_i(grantedEntry_i),
    .freeEntry_o(freeEntry_o),
    .freeValid_o(freeValid_o),
    .freeCnt_o(freeCnt_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timeout");
  end

  function automatic logic [DW*LOG-1:0] exp_entries();
    logic [DW*LOG-1:0] v = '0;
    for (int k = 0; k < DW && k < sb.size(); k++) v[k*LOG +: LOG] = LOG'(sb[k]);
    return v;
  endfunction

  function automatic logic [GW*LOG-1:0] lanes(input int l2, input int l1, input int l0);
    return {LOG'(l2), LOG'(l1), LOG'(l0)};
  endfunction

  task automatic model_full(input bit clr_err);
    sb.delete();
    out_q.delete();
    for (int i = 0; i < DEPTH; i++) sb.push_back(i);
    exp_cnt = DEPTH;
    if (clr_err) exp_err = 1'b0;
  endtask

  task automatic idle_inputs();
    flush_i        = 1'b0;
    alloc_i        = 1'b0;
    grantedValid_i = '0;
    grantedEntry_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_full(1'b1);
  endtask

  // Drives one cycle from a negedge, updates the model at the edge, returns at the next negedge.
  task automatic drive_cycle(input bit a, input logic [GW-1:0] gv, input logic [GW*LOG-1:0] ge);
    bit acc;
    int pop;
    int nc;
    alloc_i        = a;
    grantedValid_i = gv;
    grantedEntry_i = ge;
    @(posedge clk);
    acc = a && (exp_cnt >= DW);
    if (a && !acc) exp_err = 1'b1;
    pop = 0;
    for (int g = 0; g < GW; g++) if (gv[g]) pop++;
    nc = exp_cnt - (acc ? DW : 0) + pop;
    if (acc) for (int k = 0; k < DW; k++) out_q.push_back(sb.pop_front());
    if (nc > DEPTH) begin
      exp_err = 1'b1;
      exp_cnt = DEPTH;
    end else begin
      for (int g = 0; g < GW; g++) if (gv[g]) sb.push_back(int'(ge[g*LOG +: LOG]));
      exp_cnt = nc;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic drive_flush(input bit a, input logic [GW-1:0] gv, input logic [GW*LOG-1:0] ge);
    flush_i        = 1'b1;
    alloc_i        = a;
    grantedValid_i = gv;
    grantedEntry_i = ge;
    @(posedge clk);
    model_full(1'b0);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (freeCnt_o !== 8'd128) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 128", freeCnt_o);
    end
    n_checks++;
    if (freeValid_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 1", freeValid_o);
    end
    n_checks++;
    if (freeEntry_o !== INIT_ENTRIES) begin
      n_fail++; $display("FAIL reset_entries: got %h expected %h", freeEntry_o, INIT_ENTRIES);
    end
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_error: got %b expected 0", error_o);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (freeEntry_o !== exp_entries()) begin
        n_fail++; $display("FAIL drain_entries[%0d]: got %h expected %h", i, freeEntry_o, exp_entries());
      end
      drive_cycle(1'b1, '0, '0);
    end
    n_checks++;
    if (freeCnt_o !== 8'd0 || freeValid_o !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got cnt=%0d valid=%b expected cnt=0 valid=0", freeCnt_o, freeValid_o);
    end
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++; $display("FAIL drain_error: got %b expected 0", error_o);
    end
    drive_cycle(1'b1, '0, '0);
    n_checks++;
    if (freeCnt_o !== 8'd0 || freeValid_o !== 1'b0) begin
      n_fail++; $display("FAIL underflow_state: got cnt=%0d valid=%b expected cnt=0 valid=0", freeCnt_o, freeValid_o);
    end
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++; $display("FAIL underflow_error: got %b expected 1", error_o);
    end
  endtask

  task automatic test_compaction();
    drive_cycle(1'b0, 3'b101, lanes(9, 99, 5));
    n_checks++;
    if (freeCnt_o !== 8'd2) begin
      n_fail++; $display("FAIL compact_cnt1: got %0d expected 2", freeCnt_o);
    end
    drive_cycle(1'b0, 3'b011, lanes(100, 7, 12));
    n_checks++;
    if (freeCnt_o !== 8'd4 || freeValid_o !== 1'b1) begin
      n_fail++; $display("FAIL compact_cnt2: got cnt=%0d valid=%b expected cnt=4 valid=1", freeCnt_o, freeValid_o);
    end
    n_checks++;
    if (freeEntry_o !== {7'd7, 7'd12, 7'd9, 7'd5}) begin
      n_fail++; $display("FAIL compact_entries: got %h expected %h", freeEntry_o, {7'd7, 7'd12, 7'd9, 7'd5});
    end
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++; $display("FAIL error_sticky: got %b expected 1", error_o);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b0, 3'b111, lanes(22, 21, 20));
    drive_cycle(1'b0, 3'b001, lanes(0, 0, 23));
    n_checks++;
    if (freeCnt_o !== 8'd8) begin
      n_fail++; $display("FAIL b2b_cnt8: got %0d expected 8", freeCnt_o);
    end
    n_checks++;
    if (freeEntry_o !== {7'd7, 7'd12, 7'd9, 7'd5}) begin
      n_fail++; $display("FAIL b2b_head: got %h expected %h", freeEntry_o, {7'd7, 7'd12, 7'd9, 7'd5});
    end
    drive_cycle(1'b1, 3'b111, lanes(42, 41, 40));
    n_checks++;
    if (freeCnt_o !== 8'd7) begin
      n_fail++; $display("FAIL b2b_cnt7: got %0d expected 7", freeCnt_o);
    end
    n_checks++;
    if (freeEntry_o !== {7'd23, 7'd22, 7'd21, 7'd20}) begin
      n_fail++; $display("FAIL b2b_older_first: got %h expected %h", freeEntry_o, {7'd23, 7'd22, 7'd21, 7'd20});
    end
    drive_cycle(1'b1, '0, '0);
    n_checks++;
    if (freeCnt_o !== 8'd3 || freeValid_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cnt3: got cnt=%0d valid=%b expected cnt=3 valid=0", freeCnt_o, freeValid_o);
    end
    n_checks++;
    if (freeEntry_o[3*LOG-1:0] !== {7'd42, 7'd41, 7'd40}) begin
      n_fail++; $display("FAIL b2b_freed: got %h expected %h", freeEntry_o[3*LOG-1:0], {7'd42, 7'd41, 7'd40});
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    drive_cycle(1'b0, 3'b001, lanes(0, 0, 77));
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++; $display("FAIL overflow_error: got %b expected 1", error_o);
    end
    n_checks++;
    if (freeCnt_o !== 8'd128 || freeEntry_o !== INIT_ENTRIES) begin
      n_fail++; $display("FAIL overflow_state: got cnt=%0d entries=%h expected cnt=128 entries=%h",
                         freeCnt_o, freeEntry_o, INIT_ENTRIES);
    end
    drive_flush(1'b0, '0, '0);
    n_checks++;
    if (error_o !== 1'b1 || freeCnt_o !== 8'd128) begin
      n_fail++; $display("FAIL flush_keeps_error: got err=%b cnt=%0d expected err=1 cnt=128", error_o, freeCnt_o);
    end
  endtask

  task automatic test_random();
    int n_alloc = 0;
    apply_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      bit a;
      logic [GW-1:0] gv;
      logic [GW*LOG-1:0] ge;
      a  = (exp_cnt >= DW) && ($urandom_range(0, 1) == 1);
      gv = '0;
      ge = '0;
      for (int g = 0; g < GW; g++) begin
        if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          int idx;
          idx = $urandom_range(0, out_q.size() - 1);
          gv[g] = 1'b1;
          ge[g*LOG +: LOG] = LOG'(out_q[idx]);
          out_q.delete(idx);
        end
      end
      n_checks++;
      if (freeCnt_o !== (LOG+1)'(exp_cnt) || freeValid_o !== (exp_cnt >= DW)) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got cnt=%0d valid=%b expected cnt=%0d valid=%b",
                           cyc, freeCnt_o, freeValid_o, exp_cnt, exp_cnt >= DW);
      end
      if (a) begin
        n_alloc++;
        n_checks++;
        if (freeEntry_o !== exp_entries()) begin
          n_fail++; $display("FAIL rand_order[%0d]: got %h expected %h", cyc, freeEntry_o, exp_entries());
        end
      end
      drive_cycle(a, gv, ge);
    end
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++; $display("FAIL rand_error: got %b expected 0", error_o);
    end
    while (exp_cnt >= DW) begin
      n_checks++;
      if (freeEntry_o !== exp_entries()) begin
        n_fail++; $display("FAIL rand_drain: got %h expected %h", freeEntry_o, exp_entries());
      end
      drive_cycle(1'b1, '0, '0);
    end
  endtask

  task automatic test_flush();
    logic [GW-1:0] gv = '0;
    logic [GW*LOG-1:0] ge = '0;
    for (int g = 0; g < 2; g++) begin
      if (out_q.size() > g) begin
        gv[g] = 1'b1;
        ge[g*LOG +: LOG] = LOG'(out_q[g]);
      end
    end
    drive_flush(1'b1, gv, ge);
    n_checks++;
    if (freeCnt_o !== 8'd128 || freeEntry_o !== INIT_ENTRIES) begin
      n_fail++; $display("FAIL flush_state: got cnt=%0d entries=%h expected cnt=128 entries=%h",
                         freeCnt_o, freeEntry_o, INIT_ENTRIES);
    end
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_error: got %b expected 0", error_o);
    end
    drive_cycle(1'b1, '0, '0);
    drive_cycle(1'b1, 3'b011, lanes(0, 5, 1));
    n_checks++;
    if (freeCnt_o !== (LOG+1)'(exp_cnt) || freeEntry_o !== exp_entries()) begin
      n_fail++; $display("FAIL pre_reset: got cnt=%0d entries=%h expected cnt=%0d entries=%h",
                         freeCnt_o, freeEntry_o, exp_cnt, exp_entries());
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (freeCnt_o !== 8'd128 || freeEntry_o !== INIT_ENTRIES || error_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got cnt=%0d entries=%h err=%b expected cnt=128 entries=%h err=0",
                         freeCnt_o, freeEntry_o, error_o, INIT_ENTRIES);
    end
    @(negedge clk);
    reset = 1'b1;
    model_full(1'b1);
  endtask

  initial begin
    test_reset();
    test_drain();
    test_compaction();
    test_back_to_back();
    test_overflow();
    test_random();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
